// File: rtl/adau1761_pkg.sv
// Shared definitions for the ADAU1761 configuration sequencer.
//   - command opcodes and the 34-bit command-table entry layout
//   - named ADAU1761 register addresses used by the board tables
//   - sequencer state encoding (also exported on the debug port)
package adau1761_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_DELAY = 2'd1,
    OP_POLL  = 2'd2,
    OP_END   = 2'd3
  } op_e;

  // op[1:0], addr[15:0], data[7:0], mask[7:0]
  typedef struct packed {
    op_e         op;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  mask;
  } entry_t;

  localparam int ENTRY_W = 34;

  localparam logic [15:0] REG_CLK_CTRL  = 16'h4000;
  localparam logic [15:0] REG_PLL_CTRL  = 16'h4002;
  localparam logic [15:0] REG_SER_PORT0 = 16'h4015;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_ISSUE    = 4'd3,
    ST_WAIT_RSP = 4'd4,
    ST_DELAY    = 4'd5,
    ST_CHECK    = 4'd6,
    ST_GAP      = 4'd7,
    ST_DONE     = 4'd8,
    ST_ERROR    = 4'd9
  } state_e;

  function automatic entry_t mk_entry(input op_e op, input logic [15:0] addr,
                                      input logic [7:0] data, input logic [7:0] mask);
    entry_t e;
    e.op   = op;
    e.addr = addr;
    e.data = data;
    e.mask = mask;
    return e;
  endfunction

endpackage

// File: rtl/adau1761_config_rom.sv
// Board command table for the ADAU1761 bring-up sequence.
// Synchronous read, one cycle latency: entry reflects the index sampled
// on the previous rising edge of clk.
//   clk    in   system clock
//   index  in   table index
//   entry  out  registered command-table entry
// Unused slots decode as END so a short table terminates cleanly.
module adau1761_config_rom
  import adau1761_pkg::*;
#(
  parameter  int NUM_ENTRIES = 32,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] index,
  output entry_t           entry
);

  always_ff @(posedge clk) begin
    case (index)
      IDX_W'(0): entry <= mk_entry(OP_WRITE, REG_CLK_CTRL,  8'h01, 8'hFF);
      IDX_W'(1): entry <= mk_entry(OP_WRITE, REG_SER_PORT0, 8'h01, 8'hFF);
      IDX_W'(2): entry <= mk_entry(OP_DELAY, 16'h0000,      8'h03, 8'h00);
      // Wait for PLL lock (bit 1 of the PLL control register).
      IDX_W'(3): entry <= mk_entry(OP_POLL,  REG_PLL_CTRL,  8'h02, 8'h02);
      IDX_W'(4): entry <= mk_entry(OP_END,   16'h0000,      8'h00, 8'h00);
      default:   entry <= mk_entry(OP_END,   16'h0000,      8'h00, 8'h00);
    endcase
  end

endmodule

// File: rtl/adau1761_config_sequencer.sv
// Walks the codec command table and feeds one register transaction at a
// time to the SPI transaction engine, waiting for each completion.
//   clk, resetn          clock, async active-low reset
//   start                pulse, (re)starts from entry 0 when not busy
//   busy/done/error      sequence status; error_index = failing entry
//   txn_*                request channel to the SPI engine
//   rsp_valid/rsp_rdata  completion pulse and read data
//   dbg_state            current FSM state
//
// Request channel: a request is transferred on the cycle where txn_valid
// and txn_ready are both high. While txn_valid is high and txn_ready low,
// txn_rnw/txn_addr/txn_wdata hold. txn_ready with txn_valid low is ignored.
// Only one request is ever outstanding; the next is not raised before the
// matching rsp_valid.
module adau1761_config_sequencer
  import adau1761_pkg::*;
#(
  parameter  int NUM_ENTRIES = 32,
  parameter  int DELAY_SHIFT = 10,
  parameter  int POLL_MAX    = 255,
  parameter  int POLL_GAP    = 64,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] error_index,
  output logic             txn_valid,
  input  logic             txn_ready,
  output logic             txn_rnw,
  output logic [15:0]      txn_addr,
  output logic [7:0]       txn_wdata,
  input  logic             rsp_valid,
  input  logic [7:0]       rsp_rdata,
  output state_e           dbg_state
);

  localparam int DLY_W = 8 + DELAY_SHIFT;
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  state_e           state;
  logic [IDX_W-1:0] index;
  entry_t           entry;
  logic [7:0]       poll_cnt;
  logic [7:0]       poll_nxt;
  logic [7:0]       rdata_q;
  logic [DLY_W-1:0] delay_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_index;
  logic             poll_match;

  adau1761_config_rom #(.NUM_ENTRIES(NUM_ENTRIES)) u_rom (
    .clk   (clk),
    .index (index),
    .entry (entry)
  );

  // The ROM keeps re-reading the current index, so entry stays valid for
  // the whole time the FSM works on it.
  assign last_index = (index == IDX_W'(NUM_ENTRIES - 1));
  assign poll_match = ((rdata_q & entry.mask) == (entry.data & entry.mask));
  assign poll_nxt   = poll_cnt + 8'd1;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      error_index <= '0;
      txn_valid   <= 1'b0;
      txn_rnw     <= 1'b0;
      txn_addr    <= '0;
      txn_wdata   <= '0;
      index       <= '0;
      poll_cnt    <= '0;
      rdata_q     <= '0;
      delay_cnt   <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            index    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            poll_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          case (entry.op)
            OP_WRITE, OP_POLL: begin
              txn_valid <= 1'b1;
              txn_rnw   <= (entry.op == OP_POLL);
              txn_addr  <= entry.addr;
              txn_wdata <= (entry.op == OP_POLL) ? 8'h00 : entry.data;
              state     <= ST_ISSUE;
            end
            OP_DELAY: begin
              delay_cnt <= DLY_W'(entry.data) << DELAY_SHIFT;
              state     <= ST_DELAY;
            end
            default: begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end
          endcase
        end
        ST_ISSUE: begin
          if (txn_ready) begin
            txn_valid <= 1'b0;
            state     <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_valid) begin
            if (entry.op == OP_POLL) begin
              rdata_q <= rsp_rdata;
              state   <= ST_CHECK;
            end else if (last_index) begin
              error       <= 1'b1;
              error_index <= IDX_W'(NUM_ENTRIES - 1);
              busy        <= 1'b0;
              state       <= ST_ERROR;
            end else begin
              index <= index + 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_DELAY: begin
          // Leaves on the cycle the count would reach zero, so a load of N
          // spends N cycles here and a load of 0 spends one.
          if (delay_cnt < DLY_W'(2)) begin
            if (last_index) begin
              error       <= 1'b1;
              error_index <= IDX_W'(NUM_ENTRIES - 1);
              busy        <= 1'b0;
              state       <= ST_ERROR;
            end else begin
              index <= index + 1'b1;
              state <= ST_FETCH;
            end
          end else begin
            delay_cnt <= delay_cnt - 1'b1;
          end
        end
        ST_CHECK: begin
          if (poll_match) begin
            poll_cnt <= '0;
            if (last_index) begin
              error       <= 1'b1;
              error_index <= IDX_W'(NUM_ENTRIES - 1);
              busy        <= 1'b0;
              state       <= ST_ERROR;
            end else begin
              index <= index + 1'b1;
              state <= ST_FETCH;
            end
          end else if (poll_nxt == 8'(POLL_MAX)) begin
            poll_cnt    <= poll_nxt;
            error       <= 1'b1;
            error_index <= index;
            busy        <= 1'b0;
            state       <= ST_ERROR;
          end else begin
            poll_cnt <= poll_nxt;
            gap_cnt  <= GAP_W'(POLL_GAP);
            state    <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt < GAP_W'(2)) begin
            txn_valid <= 1'b1;
            txn_rnw   <= 1'b1;
            txn_addr  <= entry.addr;
            txn_wdata <= 8'h00;
            state     <= ST_ISSUE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adau1761_config_sequencer.sv
// Directed bench for adau1761_config_sequencer with the board table:
//   0 WRITE 4000/01, 1 WRITE 4015/01, 2 DELAY 3, 3 POLL 4002 data 02 mask 02, 4 END
// A behavioural SPI engine answers requests with a programmable stall and
// a fixed response latency; accepted requests go to acc_q and are compared
// against the expected queue exp_q built in each test.
module tb_adau1761_config_sequencer;
  import adau1761_pkg::*;

  localparam int NUM_ENTRIES = 32;
  localparam int IDX_W       = 5;
  localparam int DELAY_SHIFT = 2;
  localparam int POLL_MAX    = 4;
  localparam int POLL_GAP    = 8;
  localparam int RSP_LAT     = 3;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic             start     = 1'b0;
  logic             txn_ready = 1'b0;
  logic             rsp_valid = 1'b0;
  logic [7:0]       rsp_rdata = 8'h00;
  logic             busy, done, error, txn_valid, txn_rnw;
  logic [IDX_W-1:0] error_index;
  logic [15:0]      txn_addr;
  logic [7:0]       txn_wdata;
  state_e           dbg_state;

  adau1761_config_sequencer #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .DELAY_SHIFT (DELAY_SHIFT),
    .POLL_MAX    (POLL_MAX),
    .POLL_GAP    (POLL_GAP)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .error_index (error_index),
    .txn_valid   (txn_valid),
    .txn_ready   (txn_ready),
    .txn_rnw     (txn_rnw),
    .txn_addr    (txn_addr),
    .txn_wdata   (txn_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [24:0] exp_q[$];
  logic [24:0] acc_q[$];
  int          acc_cyc_q[$];
  logic [7:0]  poll_q[$];
  logic [7:0]  poll_default = 8'h00;
  int          stall_cfg = 0;
  int          stall_left = 0;
  bit          pend = 1'b0;
  int          rsp_wait = 0;
  logic [7:0]  pend_rdata = 8'h00;
  logic [24:0] ref_req = '0;
  int          unstable_cnt = 0;
  int          stall_obs = 0;
  int          overlap_cnt = 0;
  int          delay_cycles = 0;
  int          valid_in_delay = 0;
  bit          stray_req = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [24:0] req(input bit rnw, input logic [15:0] a, input logic [7:0] d);
    return {rnw, a, d};
  endfunction

  // ---------------- SPI engine model (drives on negedge) ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      txn_ready  = 1'b0;
      rsp_valid  = 1'b0;
      pend       = 1'b0;
      stall_left = stall_cfg;
    end else begin
      rsp_valid = 1'b0;
      if (stray_req) begin
        rsp_valid = 1'b1;
        rsp_rdata = 8'hA5;
        stray_req = 1'b0;
      end
      if (pend) begin
        rsp_wait--;
        if (rsp_wait == 0) begin
          rsp_valid = 1'b1;
          rsp_rdata = pend_rdata;
          pend      = 1'b0;
        end
      end
      if (txn_valid && pend) overlap_cnt++;
      if (txn_valid) begin
        if (stall_left == stall_cfg) ref_req = {txn_rnw, txn_addr, txn_wdata};
        else if ({txn_rnw, txn_addr, txn_wdata} !== ref_req) unstable_cnt++;
        if (stall_left > 0) begin
          txn_ready = 1'b0;
          stall_left--;
          stall_obs++;
        end else begin
          txn_ready = 1'b1;
          acc_q.push_back({txn_rnw, txn_addr, txn_wdata});
          acc_cyc_q.push_back(cyc);
          pend     = 1'b1;
          rsp_wait = RSP_LAT;
          if (!txn_rnw) pend_rdata = 8'h00;
          else if (poll_q.size() > 0) pend_rdata = poll_q.pop_front();
          else pend_rdata = poll_default;
          stall_left = stall_cfg;
        end
      end else begin
        txn_ready = 1'b1;
      end
    end
  end

  // DELAY-window monitor
  always @(negedge clk) begin
    if (resetn && dbg_state == ST_DELAY) begin
      delay_cycles++;
      if (txn_valid) valid_in_delay++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    acc_q.delete();
    acc_cyc_q.delete();
    exp_q.delete();
    unstable_cnt   = 0;
    stall_obs      = 0;
    overlap_cnt    = 0;
    delay_cycles   = 0;
    valid_in_delay = 0;
  endtask

  task automatic set_stall(input int n);
    stall_cfg  = n;
    stall_left = n;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done || error) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input state_e s, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (dbg_state == s) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    checks++; if (error_index !== 5'd0) begin errors++; $display("FAIL reset_error_index: got %0d expected 0", error_index); end
    checks++; if (txn_valid !== 1'b0) begin errors++; $display("FAIL reset_txn_valid: got %b expected 0", txn_valid); end
    checks++; if (txn_rnw !== 1'b0) begin errors++; $display("FAIL reset_txn_rnw: got %b expected 0", txn_rnw); end
    checks++; if (txn_addr !== 16'h0000) begin errors++; $display("FAIL reset_txn_addr: got %h expected 0000", txn_addr); end
    checks++; if (txn_wdata !== 8'h00) begin errors++; $display("FAIL reset_txn_wdata: got %h expected 00", txn_wdata); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || txn_valid !== 1'b0) begin errors++; $display("FAIL idle_no_start: busy=%b txn_valid=%b expected 0/0", busy, txn_valid); end
  endtask

  task automatic test_write_sequence();
    bit ok;
    clear_obs();
    set_stall(0);
    poll_q.delete();
    poll_q.push_back(8'h02);
    exp_q.push_back(req(1'b0, 16'h4000, 8'h01));
    exp_q.push_back(req(1'b0, 16'h4015, 8'h01));
    exp_q.push_back(req(1'b1, 16'h4002, 8'h00));
    pulse_start();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL seq_busy_after_start: got %b expected 1", busy); end
    wait_end(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seq_timeout: done/error not seen within 2000 cycles"); end
    checks++; if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL seq_req_count: got %0d expected %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL seq_req[%0d]: got %h expected %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL seq_status: done=%b busy=%b error=%b expected 1/0/0", done, busy, error); end
    // DELAY data=3 with DELAY_SHIFT=2 waits 12 cycles
    checks++; if (delay_cycles !== 12) begin errors++; $display("FAIL seq_delay_cycles: got %0d expected 12", delay_cycles); end
    checks++; if (valid_in_delay !== 0) begin errors++; $display("FAIL seq_valid_in_delay: got %0d expected 0", valid_in_delay); end
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL seq_outstanding: got %0d overlaps expected 0", overlap_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_obs();
    set_stall(5);
    poll_q.delete();
    poll_q.push_back(8'h02);
    exp_q.push_back(req(1'b0, 16'h4000, 8'h01));
    exp_q.push_back(req(1'b0, 16'h4015, 8'h01));
    exp_q.push_back(req(1'b1, 16'h4002, 8'h00));
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();   // while busy: must not restart
    wait_end(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: done/error not seen within 2000 cycles"); end
    checks++; if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_req_count: got %0d expected %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_req[%0d]: got %h expected %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (stall_obs !== 15) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 15", stall_obs); end
    checks++; if (unstable_cnt !== 0) begin errors++; $display("FAIL bp_stability: got %0d changes expected 0", unstable_cnt); end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL bp_status: done=%b error=%b expected 1/0", done, error); end
    set_stall(0);
  endtask

  task automatic test_poll_retry();
    bit ok;
    int rd_cyc[$];
    clear_obs();
    poll_q.delete();
    poll_q.push_back(8'h00);
    poll_q.push_back(8'hFD);   // every bit except the masked one set
    poll_q.push_back(8'h02);
    exp_q.push_back(req(1'b0, 16'h4000, 8'h01));
    exp_q.push_back(req(1'b0, 16'h4015, 8'h01));
    for (int i = 0; i < 3; i++) exp_q.push_back(req(1'b1, 16'h4002, 8'h00));
    pulse_start();
    wait_end(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL poll_timeout_wait: done/error not seen within 3000 cycles"); end
    checks++; if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL poll_req_count: got %0d expected %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL poll_req[%0d]: got %h expected %h", i, acc_q[i], exp_q[i]); end
    end
    for (int i = 0; i < acc_q.size(); i++) if (acc_q[i][24]) rd_cyc.push_back(acc_cyc_q[i]);
    for (int i = 1; i < rd_cyc.size(); i++) begin
      checks++; if (rd_cyc[i] - rd_cyc[i-1] < POLL_GAP) begin errors++; $display("FAIL poll_gap[%0d]: got %0d cycles expected >= %0d", i, rd_cyc[i] - rd_cyc[i-1], POLL_GAP); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL poll_status: done=%b error=%b busy=%b expected 1/0/0", done, error, busy); end
  endtask

  task automatic test_poll_timeout();
    bit ok;
    clear_obs();
    poll_q.delete();
    poll_default = 8'h00;
    exp_q.push_back(req(1'b0, 16'h4000, 8'h01));
    exp_q.push_back(req(1'b0, 16'h4015, 8'h01));
    for (int i = 0; i < 4; i++) exp_q.push_back(req(1'b1, 16'h4002, 8'h00));
    pulse_start();
    wait_end(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_wait: done/error not seen within 3000 cycles"); end
    checks++; if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL to_req_count: got %0d expected %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL to_req[%0d]: got %h expected %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error: got %b expected 1", error); end
    checks++; if (error_index !== 5'd3) begin errors++; $display("FAIL to_error_index: got %0d expected 3", error_index); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL to_busy_done: busy=%b done=%b expected 0/0", busy, done); end
    repeat (4) @(negedge clk);
    checks++; if (acc_q.size() !== 6) begin errors++; $display("FAIL to_no_extra_reads: got %0d requests expected 6", acc_q.size()); end
  endtask

  task automatic test_restart();
    bit ok;
    clear_obs();
    poll_q.delete();
    poll_q.push_back(8'h02);
    exp_q.push_back(req(1'b0, 16'h4000, 8'h01));
    exp_q.push_back(req(1'b0, 16'h4015, 8'h01));
    exp_q.push_back(req(1'b1, 16'h4002, 8'h00));
    pulse_start();
    checks++; if (error !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rs_clear: error=%b busy=%b done=%b expected 0/1/0", error, busy, done); end
    wait_end(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rs_wait: done/error not seen within 2000 cycles"); end
    checks++; if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL rs_req_count: got %0d expected %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rs_req[%0d]: got %h expected %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL rs_status: done=%b error=%b expected 1/0", done, error); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    // reset while waiting for a response
    clear_obs();
    set_stall(0);
    pulse_start();
    wait_state(ST_WAIT_RSP, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_reach_wait_rsp: state %0d not reached within 50 cycles", ST_WAIT_RSP); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL rm_async_status: busy=%b done=%b error=%b expected 0/0/0", busy, done, error); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rm_async_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE || busy !== 1'b0 || txn_valid !== 1'b0) begin errors++; $display("FAIL rm_stray_rsp: state=%0d busy=%b txn_valid=%b expected idle/0/0", dbg_state, busy, txn_valid); end

    // reset while a request is stalled: txn_valid must drop at once
    set_stall(50);
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txn_valid) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rm_reach_issue: txn_valid not seen within 20 cycles"); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (txn_valid !== 1'b0 || txn_addr !== 16'h0000 || txn_wdata !== 8'h00) begin errors++; $display("FAIL rm_async_txn: valid=%b addr=%h wdata=%h expected 0/0000/00", txn_valid, txn_addr, txn_wdata); end
    @(negedge clk);
    set_stall(0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // full run after reset
    clear_obs();
    poll_q.delete();
    poll_q.push_back(8'h02);
    exp_q.push_back(req(1'b0, 16'h4000, 8'h01));
    exp_q.push_back(req(1'b0, 16'h4015, 8'h01));
    exp_q.push_back(req(1'b1, 16'h4002, 8'h00));
    pulse_start();
    wait_end(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_run_wait: done/error not seen within 2000 cycles"); end
    checks++; if (acc_q.size() !== exp_q.size()) begin errors++; $display("FAIL rm_req_count: got %0d expected %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rm_req[%0d]: got %h expected %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_status: done=%b error=%b busy=%b expected 1/0/0", done, error, busy); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_sequence();
    test_backpressure();
    test_poll_retry();
    test_poll_timeout();
    test_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
